// File: rtl/rf_arb_pkg.sv
// Shared defaults and types for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int W    = 8;
  localparam int D    = 3;
  localparam int NREQ = 3;
  localparam logic [(2**D)-1:0] RO_MASK = 8'b0011_0010;

  typedef logic [$clog2(NREQ)-1:0] req_idx_t;
  typedef logic [D-1:0]            rf_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first valid requester at or after ptr, wrapping.
module rr_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NREQ = rf_arb_pkg::NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Offset k is tried before k+1, so the lowest rotation distance from ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any && valid[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          any      = 1'b1;
          grant[i] = 1'b1;
          idx      = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin sharing of the register file write port with a one-entry output
// stage, write protection of constant registers and a pending-write mask.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int                  W       = rf_arb_pkg::W,
  parameter int                  D       = rf_arb_pkg::D,
  parameter int                  NREQ    = rf_arb_pkg::NREQ,
  parameter logic [(2**D)-1:0]   RO_MASK = rf_arb_pkg::RO_MASK
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         ReqValid,
  input  logic [NREQ*D-1:0]       ReqAddr,
  input  logic [NREQ*W-1:0]       ReqData,
  output logic [NREQ-1:0]         ReqReady,
  input  logic                    Hold,
  output logic                    WriteEn,
  output logic [D-1:0]            Waddr,
  output logic [W-1:0]            DataIn,
  output logic [(2**D)-1:0]       PendMask,
  output logic [$clog2(NREQ)-1:0] GrantIdx,
  output logic                    RoErr
);

  localparam int IW = $clog2(NREQ);

  logic          out_valid;
  logic [D-1:0]  out_addr;
  logic [W-1:0]  out_data;
  logic [IW-1:0] out_idx;
  logic [IW-1:0] rr_ptr;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            any;
  logic            acc;
  logic            hs;
  logic            ro;
  logic [IW-1:0]   next_ptr;

  logic [D-1:0] addr_arr [NREQ];
  logic [W-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = ReqAddr[i*D +: D];
    assign data_arr[i] = ReqData[i*W +: W];
  end

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .valid (ReqValid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  // A new write may enter whenever the stage is empty or drains this cycle.
  assign acc      = Reset & (!out_valid | !Hold);
  assign ReqReady = acc ? grant : '0;
  assign hs       = acc & any;
  assign ro       = RO_MASK[addr_arr[gidx]];
  assign next_ptr = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      rr_ptr    <= '0;
      RoErr     <= 1'b0;
    end else begin
      RoErr <= 1'b0;
      if (hs) begin
        rr_ptr <= next_ptr;
        // Protected targets are consumed from the requester but never reach the RF.
        if (ro) begin
          out_valid <= 1'b0;
          RoErr     <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_addr  <= addr_arr[gidx];
          out_data  <= data_arr[gidx];
          out_idx   <= gidx;
        end
      end else if (!Hold) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    PendMask           = '0;
    PendMask[out_addr] = out_valid;
  end

  assign WriteEn  = out_valid & !Hold;
  assign Waddr    = out_addr;
  assign DataIn   = out_data;
  assign GrantIdx = out_idx;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed, table-driven bench for rf_write_arbiter with a small register-file model.
module tb_rf_write_arbiter;

  logic       Clk;
  logic       Reset;
  logic [2:0] ReqValid;
  logic [8:0] ReqAddr;
  logic [23:0] ReqData;
  logic [2:0] ReqReady;
  logic       Hold;
  logic       WriteEn;
  logic [2:0] Waddr;
  logic [7:0] DataIn;
  logic [7:0] PendMask;
  logic [1:0] GrantIdx;
  logic       RoErr;

  int checks = 0;
  int errors = 0;

  logic [7:0] rf [8];

  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [8:0]  addr;
    logic [23:0] data;
    logic        hold;
    logic [2:0]  ready;
    logic        we;
    logic [2:0]  waddr;
    logic [7:0]  wdata;
    logic [7:0]  pend;
    logic [1:0]  idx;
    logic        roerr;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  rf_write_arbiter dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqAddr  (ReqAddr),
    .ReqData  (ReqData),
    .ReqReady (ReqReady),
    .Hold     (Hold),
    .WriteEn  (WriteEn),
    .Waddr    (Waddr),
    .DataIn   (DataIn),
    .PendMask (PendMask),
    .GrantIdx (GrantIdx),
    .RoErr    (RoErr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Register-file model fed only by the arbiter's write port.
  always @(posedge Clk) begin
    if (WriteEn === 1'b1) rf[Waddr] <= DataIn;
  end

  task automatic compare(input string name, input int v, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %0h expected %0h", name, v, act, exp);
    end
  endtask

  task automatic applyStimulus(input int v);
    Reset    = vecs[v].rst;
    ReqValid = vecs[v].valid;
    ReqAddr  = vecs[v].addr;
    ReqData  = vecs[v].data;
    Hold     = vecs[v].hold;
  endtask

  task automatic checkOutput(input int v);
    compare("ReqReady", v, 32'(ReqReady), 32'(vecs[v].ready));
    compare("WriteEn",  v, 32'(WriteEn),  32'(vecs[v].we));
    compare("PendMask", v, 32'(PendMask), 32'(vecs[v].pend));
    compare("RoErr",    v, 32'(RoErr),    32'(vecs[v].roerr));
    if (vecs[v].we) begin
      compare("Waddr",    v, 32'(Waddr),    32'(vecs[v].waddr));
      compare("DataIn",   v, 32'(DataIn),   32'(vecs[v].wdata));
      compare("GrantIdx", v, 32'(GrantIdx), 32'(vecs[v].idx));
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;

    //           rst  valid   addr {a2,a1,a0}        data {d2,d1,d0}          hold  ready   we  waddr wdata  pend   idx roerr
    // Reset with all requesters valid, then continuous round robin.
    vecs[0]  = '{1'b0, 3'b111, {3'd6,3'd3,3'd2}, {8'hC2,8'hB1,8'hA0}, 1'b0, 3'b000, 1'b0, 3'd0, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[1]  = '{1'b0, 3'b111, {3'd6,3'd3,3'd2}, {8'hC2,8'hB1,8'hA0}, 1'b0, 3'b000, 1'b0, 3'd0, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[2]  = '{1'b1, 3'b111, {3'd6,3'd3,3'd2}, {8'hC2,8'hB1,8'hA0}, 1'b0, 3'b001, 1'b0, 3'd0, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[3]  = '{1'b1, 3'b111, {3'd6,3'd3,3'd2}, {8'hC2,8'hB1,8'hA0}, 1'b0, 3'b010, 1'b1, 3'd2, 8'hA0, 8'h04, 2'd0, 1'b0};
    vecs[4]  = '{1'b1, 3'b111, {3'd6,3'd3,3'd2}, {8'hC2,8'hB1,8'hA0}, 1'b0, 3'b100, 1'b1, 3'd3, 8'hB1, 8'h08, 2'd1, 1'b0};
    vecs[5]  = '{1'b1, 3'b111, {3'd6,3'd3,3'd2}, {8'hC2,8'hB1,8'hA0}, 1'b0, 3'b001, 1'b1, 3'd6, 8'hC2, 8'h40, 2'd2, 1'b0};
    // req1 targets protected r4: accepted, dropped, RoErr pulse.
    vecs[6]  = '{1'b1, 3'b010, {3'd6,3'd4,3'd2}, {8'hC2,8'h55,8'hA0}, 1'b0, 3'b010, 1'b1, 3'd2, 8'hA0, 8'h04, 2'd0, 1'b0};
    vecs[7]  = '{1'b1, 3'b000, {3'd6,3'd4,3'd2}, {8'hC2,8'h55,8'hA0}, 1'b0, 3'b000, 1'b0, 3'd0, 8'h00, 8'h00, 2'd0, 1'b1};
    // rr_ptr now 2: req0 (r7, 3C) is still found by wrap-around, then held 3 cycles.
    vecs[8]  = '{1'b1, 3'b001, {3'd6,3'd4,3'd7}, {8'hC2,8'h55,8'h3C}, 1'b0, 3'b001, 1'b0, 3'd0, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[9]  = '{1'b1, 3'b111, {3'd6,3'd4,3'd7}, {8'hC2,8'h55,8'h3C}, 1'b1, 3'b000, 1'b0, 3'd0, 8'h00, 8'h80, 2'd0, 1'b0};
    vecs[10] = '{1'b1, 3'b111, {3'd6,3'd4,3'd7}, {8'hC2,8'h55,8'h3C}, 1'b1, 3'b000, 1'b0, 3'd0, 8'h00, 8'h80, 2'd0, 1'b0};
    vecs[11] = '{1'b1, 3'b111, {3'd6,3'd4,3'd7}, {8'hC2,8'h55,8'h3C}, 1'b1, 3'b000, 1'b0, 3'd0, 8'h00, 8'h80, 2'd0, 1'b0};
    vecs[12] = '{1'b1, 3'b000, {3'd6,3'd4,3'd7}, {8'hC2,8'h55,8'h3C}, 1'b0, 3'b000, 1'b1, 3'd7, 8'h3C, 8'h80, 2'd0, 1'b0};
    vecs[13] = '{1'b1, 3'b000, {3'd6,3'd4,3'd7}, {8'hC2,8'h55,8'h3C}, 1'b0, 3'b000, 1'b0, 3'd0, 8'h00, 8'h00, 2'd0, 1'b0};
    // req1 writes r0 to move rr_ptr to 2, then req0/req2 collide on r3.
    vecs[14] = '{1'b1, 3'b010, {3'd3,3'd0,3'd3}, {8'h22,8'h77,8'h11}, 1'b0, 3'b010, 1'b0, 3'd0, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[15] = '{1'b1, 3'b101, {3'd3,3'd0,3'd3}, {8'h22,8'h77,8'h11}, 1'b0, 3'b100, 1'b1, 3'd0, 8'h77, 8'h01, 2'd1, 1'b0};
    vecs[16] = '{1'b1, 3'b001, {3'd3,3'd0,3'd3}, {8'h22,8'h77,8'h11}, 1'b0, 3'b001, 1'b1, 3'd3, 8'h22, 8'h08, 2'd2, 1'b0};
    vecs[17] = '{1'b1, 3'b000, {3'd3,3'd0,3'd3}, {8'h22,8'h77,8'h11}, 1'b0, 3'b000, 1'b1, 3'd3, 8'h11, 8'h08, 2'd0, 1'b0};
    // Reset while a held write to r6 sits in the stage: it must vanish, rr_ptr back to 0.
    vecs[18] = '{1'b1, 3'b001, {3'd6,3'd3,3'd6}, {8'hC2,8'hB1,8'h99}, 1'b0, 3'b001, 1'b0, 3'd0, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[19] = '{1'b1, 3'b000, {3'd6,3'd3,3'd6}, {8'hC2,8'hB1,8'h99}, 1'b1, 3'b000, 1'b0, 3'd0, 8'h00, 8'h40, 2'd0, 1'b0};
    vecs[20] = '{1'b0, 3'b111, {3'd6,3'd3,3'd6}, {8'hC2,8'hB1,8'h99}, 1'b1, 3'b000, 1'b0, 3'd0, 8'h00, 8'h40, 2'd0, 1'b0};
    vecs[21] = '{1'b1, 3'b111, {3'd6,3'd3,3'd2}, {8'hC2,8'hB1,8'hA0}, 1'b0, 3'b001, 1'b0, 3'd0, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[22] = '{1'b1, 3'b000, {3'd6,3'd3,3'd2}, {8'hC2,8'hB1,8'hA0}, 1'b0, 3'b000, 1'b1, 3'd2, 8'hA0, 8'h04, 2'd0, 1'b0};

    for (int v = 0; v < NV; v++) begin
      applyStimulus(v);
      @(negedge Clk);
      checkOutput(v);
      @(posedge Clk);
      #1;
    end

    // Final register-file contents: order of same-address writes, dropped and discarded writes.
    @(negedge Clk);
    compare("rf_r0", NV, 32'(rf[0]), 32'h77);
    compare("rf_r2", NV, 32'(rf[2]), 32'hA0);
    compare("rf_r3", NV, 32'(rf[3]), 32'h11);
    compare("rf_r4", NV, 32'(rf[4]), 32'h00);
    compare("rf_r6", NV, 32'(rf[6]), 32'hC2);
    compare("rf_r7", NV, 32'(rf[7]), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
